event_trace_capture: RTL
========================

// Module: event_trace_capture
// PURPOSE
//  Hardware counterpart of a value-change monitor. Watches a packed signal
//  vector and records every change as a {timestamp, value} record. Records are
//  buffered and drained by a downstream reader over a valid/ready interface.
//  Sits beside the logic under observation; the reader is a trace dump/UART
//  bridge.
// PARAMETERS
//  W       6   width of watched vector (e.g. three 2-bit regs {a,b,c})
//  TSW    16   timestamp width; free-running cycle count, wraps modulo 2**TSW
//  DEPTH   8   record buffer depth, power of 2, >= 2
//  DCW     8   drop counter width
// PORTS
//  clk        in   1         single clock, all logic on posedge
//  rst        in   1         synchronous, active-high reset
//  enable     in   1         capture enable
//  sig_in     in   W         watched vector, synchronous to clk
//  rec_valid  out  1         head record available
//  rec_ready  in   1         reader accepts head record when rec_valid && rec_ready
//  rec_ts     out  TSW       timestamp of head record
//  rec_val    out  W         sig_in value of head record
//  rec_ovf    out  1         one or more records were dropped immediately before this one
//  level      out  clog2(DEPTH)+1  records held
//  drop_cnt   out  DCW       total dropped records, saturating
// BEHAVIOUR
//  Reset: all outputs 0; buffer flushed; ts=0; prev=0; init_pending=1;
//   ovf_pending=0.
//  Timestamp:
//   - ts increments by 1 each cycle while enable=1; holds while enable=0.
//   - Wraps (2**TSW-1)->0 silently.
//  Capture (evaluated every cycle with enable=1):
//   - event = init_pending || (sig_in != prev).
//   - Record = {ts (current, pre-increment), sig_in}.
//   - prev <= sig_in every cycle, regardless of enable.
//   - init_pending is set by reset and by a rising edge of enable; it is
//     cleared when its record is accepted or dropped. This gives one "initial
//     value" record per enable session, analogous to the first monitor line.
//   - No events are generated while enable=0.
//  Buffer/handshake:
//   - Write latency: an event in cycle N appears at earliest as rec_valid in
//     cycle N+1.
//   - rec_* fields are stable while rec_valid && !rec_ready.
//   - Read and write in the same cycle are both honoured. When full,
//     simultaneous read+write is accepted (no drop).
//   - Full, event, and no read:
//     - record dropped;
//     - drop_cnt increments, saturating at all-ones;
//     - ovf_pending <= 1.
//   - The next accepted record carries rec_ovf = ovf_pending, and ovf_pending
//     clears on that write.
//   - level = writes - reads; it never exceeds DEPTH.
//  Reset mid-operation: any record in flight is lost, the buffer is emptied,
//   and drop_cnt clears. The first record after reset is an initial record
//   with ts=0 if enable=1.
// STRUCTURE
//  Shared package trace_pkg:
//   - localparam REC_W = 1+TSW+W;
//   - packing function / struct for {ovf, ts, val}.
//  Sub-module trace_fifo:
//   - synchronous FIFO, width REC_W, depth DEPTH;
//   - ports: clk, rst, wr_en, wr_data, rd_en, rd_data, full, empty, level.
//  Top level: change detector, ts counter, init/ovf flags, drop counter.
// TESTING
//  1 rst, then enable=1 with sig_in={a=0,b=0,c=0}; hold 3 cycles
//    -> exactly one record: ts=0, val=0, ovf=0.
//  2 a:0->1 at ts=1; b,c->3 at ts=1; c toggles back at ts=2
//    -> records (1,{1,3,3}) then (2,{1,3,0}); values are in order.
//  3 rec_ready=0; 10 changes with DEPTH=8
//    -> level=8, drop_cnt=2; after drain and one more change, that record
//       has ovf=1 and the following one has ovf=0.
//  4 full buffer with simultaneous rec_ready=1 and a change
//    -> no drop, level stays 8, drop_cnt unchanged.
//  5 TSW=4, change at ts=15 and next cycle -> records ts=15 then ts=0.
//  6 rst asserted while level=5 and an event is in progress
//    -> next cycle rec_valid=0, level=0, drop_cnt=0;
//       with enable=1, first record has ts=0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared defaults and record-layout helpers for the event trace capture block.
package trace_pkg;

  localparam int W_DEF     = 6;
  localparam int TSW_DEF   = 16;
  localparam int DEPTH_DEF = 8;
  localparam int DCW_DEF   = 8;

  // Record layout, MSB first: {ovf, ts, val}
  function automatic int rec_width(input int w, input int tsw);
    return 1 + tsw + w;
  endfunction

  localparam int REC_W = rec_width(W_DEF, TSW_DEF);

endpackage

// File: rtl/event_trace_capture_if.sv
// Record stream from the trace capture block to its reader, plus status.
interface event_trace_capture_if
  import trace_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int TSW   = TSW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DCW   = DCW_DEF
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic           rec_valid;
  logic           rec_ready;
  logic [TSW-1:0] rec_ts;
  logic [W-1:0]   rec_val;
  logic           rec_ovf;
  logic [LW-1:0]  level;
  logic [DCW-1:0] drop_cnt;

  modport master (
    output rec_valid, rec_ts, rec_val, rec_ovf, level, drop_cnt,
    input  rec_ready
  );

  modport slave (
    input  rec_valid, rec_ts, rec_val, rec_ovf, level, drop_cnt,
    output rec_ready
  );

endinterface

// File: rtl/trace_fifo.sv
// First-word-fall-through synchronous FIFO; a write while full is taken only
// when a read happens in the same cycle.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int WIDTH = REC_W,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    count_reg;
  logic             wr_ok;
  logic             rd_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == LW'(DEPTH));
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr_reg];
  assign level   = count_reg;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (wr_ok && !rd_ok) begin
        count_reg <= count_reg + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/event_trace_capture.sv
// Value-change monitor: records {ts, value} of a watched vector on every change
// and buffers the records for a valid/ready reader.
module event_trace_capture
  import trace_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int TSW   = TSW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DCW   = DCW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [W-1:0]         sig_in,
  event_trace_capture_if.master rec
);
  localparam int RW = rec_width(W, TSW);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [TSW-1:0] ts_reg;
  logic [W-1:0]   prev_reg;
  logic           init_pending_reg;
  logic           en_d_reg;
  logic           ovf_pending_reg;
  logic [DCW-1:0] drop_cnt_reg;

  logic           init_now;
  logic           event_now;
  logic           rd_en;
  logic           wr_en;
  logic           drop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [RW-1:0]  wr_data;
  logic [RW-1:0]  rd_data;
  logic [LW-1:0]  fifo_level;

  // A rising edge of enable starts a new session with its own initial record.
  assign init_now  = init_pending_reg || (enable && !en_d_reg);
  assign event_now = enable && (init_now || (sig_in != prev_reg));
  assign rd_en     = !fifo_empty && rec.rec_ready;
  assign wr_en     = event_now && (!fifo_full || rd_en);
  assign drop      = event_now && fifo_full && !rd_en;
  assign wr_data   = {ovf_pending_reg, ts_reg, sig_in};

  trace_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_reg           <= '0;
      prev_reg         <= '0;
      init_pending_reg <= 1'b1;
      en_d_reg         <= 1'b0;
      ovf_pending_reg  <= 1'b0;
      drop_cnt_reg     <= '0;
    end else begin
      prev_reg <= sig_in;
      en_d_reg <= enable;
      if (enable) begin
        ts_reg           <= ts_reg + 1'b1;
        init_pending_reg <= 1'b0;
      end
      if (drop) begin
        ovf_pending_reg <= 1'b1;
        if (drop_cnt_reg != '1) begin
          drop_cnt_reg <= drop_cnt_reg + 1'b1;
        end
      end else if (wr_en) begin
        ovf_pending_reg <= 1'b0;
      end
    end
  end

  // Head fields read as zero whenever no record is presented.
  assign rec.rec_valid = !fifo_empty;
  assign rec.rec_ovf   = !fifo_empty && rd_data[RW-1];
  assign rec.rec_ts    = fifo_empty ? '0 : rd_data[W +: TSW];
  assign rec.rec_val   = fifo_empty ? '0 : rd_data[W-1:0];
  assign rec.level     = fifo_level;
  assign rec.drop_cnt  = drop_cnt_reg;

endmodule
